ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 32 +++
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Bundle of fetch-unit signals: redirect, instruction-memory bus and the
// decode-facing queue head. The queue drives through "master"; the
// surrounding pipeline and memory use "slave".
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_ready;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          out_valid;
  logic [31:0]   out_code;
  logic [31:0]   out_pc;
  logic [4:0]    out_exc;
  logic          out_ready;
  logic [CW-1:0] count;

  modport master (
    input  redirect, redirect_pc, i_ready, i_rvalid, i_rdata, out_ready,
    output i_req, i_addr, out_valid, out_code, out_pc, out_exc, count
  );

  modport slave (
    output redirect, redirect_pc, i_ready, i_rvalid, i_rdata, out_ready,
    input  i_req, i_addr, out_valid, out_code, out_pc, out_exc, count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one in-order memory request at a time,
// buffers returned words (or an address-error marker) in a small circular
// FIFO for decode, and flushes/restarts on redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] BOOT_PC  = 32'h0000_3000,
  parameter logic [31:0] IM_START = 32'h0000_3000,
  parameter logic [31:0] IM_END   = 32'h0000_7000,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fpc_reg;
  logic [31:0]     req_pc_reg;
  logic            halted_reg;
  logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [31:0]     code_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic [4:0]      exc_mem  [DEPTH];

  logic            fpc_legal, not_full, head_valid;
  logic            fetch_req, fetch_fire;
  logic            push_rsp, push_exc, push, pop;
  logic [31:0]     push_code, push_pc;
  logic [4:0]      push_exc_code;

  // A fetch needs a word-aligned address inside instruction memory.
  assign fpc_legal  = (fpc_reg >= IM_START) && (fpc_reg < IM_END) && (fpc_reg[1:0] == 2'b00);
  assign not_full   = count_reg < CW'(DEPTH);
  assign head_valid = count_reg != '0;

  // Redirect flushes the FIFO, so nothing is popped or pushed that cycle.
  assign pop        = head_valid && bus.out_ready && !bus.redirect;
  assign fetch_req  = (state_reg == S_REQ) && not_full && fpc_legal && !halted_reg && !bus.redirect;
  assign fetch_fire = fetch_req && bus.i_ready;
  assign push_rsp   = (state_reg == S_WAIT) && bus.i_rvalid && !bus.redirect;
  assign push_exc   = (state_reg == S_REQ) && !fpc_legal && !halted_reg && not_full && !bus.redirect;
  assign push       = (push_rsp || push_exc) && (not_full || pop);

  // Entry written on push: a fetched word, or an address-error marker.
  always_comb begin
    push_code     = '0;
    push_pc       = fpc_reg;
    push_exc_code = EXC_ADEL;
    if (push_rsp) begin
      push_code     = bus.i_rdata;
      push_pc       = req_pc_reg;
      push_exc_code = '0;
    end
  end

  // Next-state logic for the single-outstanding-request handshake.
  always_comb begin
    state_next = state_reg;
    if (bus.redirect) begin
      case (state_reg)
        S_WAIT:  state_next = bus.i_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_next = S_DROP;
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ:   if (fetch_fire) state_next = S_WAIT;
        S_WAIT:  if (bus.i_rvalid) state_next = S_REQ;
        S_DROP:  if (bus.i_rvalid) state_next = S_REQ;
        default: state_next = S_REQ;
      endcase
    end
  end

  // Control state: FSM, fetch PC, halt flag, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_REQ;
      fpc_reg    <= BOOT_PC;
      req_pc_reg <= '0;
      halted_reg <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (bus.redirect) begin
        fpc_reg    <= bus.redirect_pc;
        halted_reg <= 1'b0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (fetch_fire) begin
          req_pc_reg <= fpc_reg;
          fpc_reg    <= fpc_reg + 32'd4;
        end
        if (push_exc) halted_reg <= 1'b1;
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (push && !pop)      count_reg <= count_reg + CW'(1);
        else if (!push && pop) count_reg <= count_reg - CW'(1);
      end
    end
  end

  // FIFO storage write; no reset needed, the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_reg] <= push_code;
      pc_mem[wr_ptr_reg]   <= push_pc;
      exc_mem[wr_ptr_reg]  <= push_exc_code;
    end
  end

  assign bus.i_req     = fetch_req;
  assign bus.i_addr    = fpc_reg;
  assign bus.out_valid = head_valid;
  assign bus.out_code  = head_valid ? code_mem[rd_ptr_reg] : '0;
  assign bus.out_pc    = head_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign bus.out_exc   = head_valid ? exc_mem[rd_ptr_reg]  : '0;
  assign bus.count     = count_reg;
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue: a driver produces random
// handshakes plus a one-slot memory, a reference model predicts the fetch
// stream, and a monitor checks every entry decode consumes.
module tb_ifetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BOOT   = 32'h0000_3000;
  localparam logic [31:0] IM_LO  = 32'h0000_3000;
  localparam logic [31:0] IM_HI  = 32'h0000_7000;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic [4:0]  exc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  ent_t        exp_q[$];
  logic [31:0] m_fpc = BOOT;
  logic [31:0] m_req_pc = '0;
  bit          m_halted = 0;
  bit          m_pending = 0;
  bit          m_drop = 0;
  bit          popped = 0;

  // One-slot instruction memory
  bit          mem_busy = 0;
  int          mem_delay = 0;
  logic [31:0] mem_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a >= IM_LO) && (a < IM_HI) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(7))
      0, 1, 2, 3: return IM_LO + 32'(4 * $urandom_range(255));
      4:          return 32'h0000_6FF0 + 32'(4 * $urandom_range(3));
      5:          return 32'h0000_3002;
      6:          return 32'h0000_2FFC;
      default:    return 32'h0000_4180;
    endcase
  endfunction

  // Drive one cycle of inputs, 1 time unit after the rising edge.
  task automatic drive_cycle(input int ready_pct, input int iready_pct,
                             input int redir_pct, input bit rst);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.out_ready = int'($urandom_range(99)) < ready_pct;
    bus.i_rvalid  = mem_busy && (mem_delay == 0);
    bus.i_rdata   = bus.i_rvalid ? mem_data : $urandom;
    bus.i_ready   = !mem_busy && (int'($urandom_range(99)) < iready_pct);
    if (!(m_drop && bus.i_rvalid) && int'($urandom_range(99)) < redir_pct) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = pick_pc();
    end else begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = $urandom;
    end
  endtask

  // Reset-state outputs, sampled in the first cycle after reset is released.
  task automatic check_reset_state();
    #1;
    check("rst_i_req",     32'(bus.i_req), 32'd1);
    check("rst_i_addr",    bus.i_addr, BOOT);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_code",  bus.out_code, 32'd0);
    check("rst_out_pc",    bus.out_pc, 32'd0);
    check("rst_out_exc",   32'(bus.out_exc), 32'd0);
    check("rst_count",     32'(bus.count), 32'd0);
  endtask

  task automatic run_phase(input int cycles, input int ready_pct,
                           input int iready_pct, input int redir_pct);
    for (int i = 0; i < cycles; i++) drive_cycle(ready_pct, iready_pct, redir_pct, 1'b0);
  endtask

  // Monitor: compares the queue head against the scoreboard whenever decode consumes.
  always begin
    @(posedge clk);
    #3;
    popped = 0;
    if (!reset) begin
      check("count", 32'(bus.count), 32'(exp_q.size()));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (!bus.out_valid) begin
        check("empty_head", bus.out_code | bus.out_pc | 32'(bus.out_exc), 32'd0);
      end else if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          popped = 1;
          $display("[TB] fetch pc=%h code=%h exc=%0d", bus.out_pc, bus.out_code, bus.out_exc);
          check("out_pc",   bus.out_pc, e.pc);
          check("out_code", bus.out_code, e.code);
          check("out_exc",  32'(bus.out_exc), 32'(e.exc));
        end
      end
    end
  end

  // Reference model and memory update, late in each cycle.
  always begin
    @(posedge clk);
    #6;
    // memory side reacts to the real handshake on the bus
    if (bus.i_rvalid) mem_busy = 0;
    else if (mem_busy && mem_delay > 0) mem_delay--;
    if (bus.i_req && bus.i_ready) begin
      mem_busy  = 1;
      mem_delay = int'($urandom_range(2));
      mem_data  = $urandom;
    end

    if (reset) begin
      exp_q.delete();
      m_fpc = BOOT; m_halted = 0; m_pending = 0; m_drop = 0;
    end else begin
      int  pre;
      bit  exp_req;
      pre     = exp_q.size() + int'(popped);
      exp_req = !m_pending && pre < DEPTH && legal(m_fpc) && !m_halted && !bus.redirect;
      check("i_req", 32'(bus.i_req), 32'(exp_req));
      if (exp_req) check("i_addr", bus.i_addr, m_fpc);

      if (bus.redirect) begin
        exp_q.delete();
        m_fpc    = bus.redirect_pc;
        m_halted = 0;
        if (m_pending) begin
          if (bus.i_rvalid) begin m_pending = 0; m_drop = 0; end
          else m_drop = 1;
        end
      end else if (m_pending) begin
        if (bus.i_rvalid) begin
          if (!m_drop) exp_q.push_back('{code: bus.i_rdata, pc: m_req_pc, exc: 5'd0});
          m_pending = 0;
          m_drop    = 0;
        end
      end else if (exp_req) begin
        if (bus.i_ready) begin
          m_req_pc  = m_fpc;
          m_fpc     = m_fpc + 32'd4;
          m_pending = 1;
        end
      end else if (!legal(m_fpc) && !m_halted && pre < DEPTH) begin
        exp_q.push_back('{code: 32'd0, pc: m_fpc, exc: 5'd4});
        m_halted = 1;
      end
    end
  end

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.i_ready = 1'b0; bus.i_rvalid = 1'b0; bus.i_rdata = '0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1'b1);
    drive_cycle(100, 100, 0, 1'b0);
    check_reset_state();

    run_phase(40, 100, 100, 0);   // straight-line fetch, decode always ready
    run_phase(30, 0, 100, 0);     // decode stalled: queue fills
    #1;
    check("full_count", 32'(bus.count), 32'(DEPTH));
    check("full_no_req", 32'(bus.i_req), 32'd0);
    run_phase(60, 50, 100, 0);    // push/pop overlap while full, pointer wrap
    run_phase(600, 50, 70, 5);
    run_phase(600, 20, 50, 8);

    // reset with a request possibly outstanding
    for (int i = 0; i < 2; i++) drive_cycle(50, 100, 0, 1'b1);
    drive_cycle(50, 100, 0, 1'b0);
    check_reset_state();

    run_phase(600, 80, 90, 6);
    run_phase(200, 100, 100, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
